// File: rtl/rom_arbiter_if.sv
// -----------------------------------------------------------------------------
// wishbone_if
// Classic Wishbone bus bundle shared by the read-only memory arbiter and its
// requesters. The primary side drives the cycle (cyc, stb, we, sel, addr,
// dat_i_s) and receives the response (dat_o_s, ack); the secondary side is
// the mirror image.
//
// Parameters
//   ADDR_W : address width
//   DATA_W : data width (sel carries one bit per byte)
// -----------------------------------------------------------------------------
interface wishbone_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  cyc;
   logic                  stb;
   logic                  we;
   logic [DATA_W/8-1:0]   sel;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     dat_i_s;
   logic [DATA_W-1:0]     dat_o_s;
   logic                  ack;

   modport primary (
      output cyc, stb, we, sel, addr, dat_i_s,
      input  dat_o_s, ack
   );

   modport secondary (
      input  cyc, stb, we, sel, addr, dat_i_s,
      output dat_o_s, ack
   );
endinterface

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
// Two-port round-robin Wishbone arbiter sharing one read-only memory between
// two requesters (typically instruction fetch and data load). Exactly one
// requester owns the memory at a time; only the owner sees ack and read data.
// After every finished or drained transaction a recovery gap of GAP_CYCLES
// idle cycles is inserted. A requester that drops cyc before its ack leaves
// the arbiter draining, so the late memory ack is swallowed instead of being
// delivered to whoever is granted next.
//
// Ports
//   clock    : sole clock, rising edge
//   reset    : synchronous, active-high
//   wb_if_p0 : requester port 0 (secondary side of the bus)
//   wb_if_p1 : requester port 1 (secondary side of the bus)
//   wb_if_s  : toward the memory (primary side of the bus)
//   grant    : registered one-hot owner, bit0 = port 0, 2'b00 with no owner
// -----------------------------------------------------------------------------
module rom_arbiter #(
   parameter int GAP_CYCLES = 1
) (
   input  logic          clock,
   input  logic          reset,
   wishbone_if.secondary wb_if_p0,
   wishbone_if.secondary wb_if_p1,
   wishbone_if.primary   wb_if_s,
   output logic [1:0]    grant
);

   localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_OWN0,
      S_OWN1,
      S_DRAIN0,
      S_DRAIN1,
      S_GAP
   } state_t;

   state_t           state, state_nxt;
   logic             last_owner, last_owner_nxt;
   logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
   logic [1:0]       grant_nxt;
   logic             req0, req1;
   logic             done_to_idle;

   assign req0 = wb_if_p0.cyc & wb_if_p0.stb;
   assign req1 = wb_if_p1.cyc & wb_if_p1.stb;

   // With no recovery gap a finished transaction returns straight to IDLE.
   assign done_to_idle = (GAP_CYCLES == 0);

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         last_owner <= 1'b1;
         gap_cnt    <= '0;
         grant      <= 2'b00;
      end else begin
         state      <= state_nxt;
         last_owner <= last_owner_nxt;
         gap_cnt    <= gap_cnt_nxt;
         grant      <= grant_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      last_owner_nxt   = last_owner;
      gap_cnt_nxt      = gap_cnt;

      wb_if_s.cyc      = 1'b0;
      wb_if_s.stb      = 1'b0;
      wb_if_s.we       = 1'b0;
      wb_if_s.sel      = '0;
      wb_if_s.addr     = '0;
      wb_if_s.dat_i_s  = '0;
      wb_if_p0.ack     = 1'b0;
      wb_if_p0.dat_o_s = '0;
      wb_if_p1.ack     = 1'b0;
      wb_if_p1.dat_o_s = '0;

      case (state)
         S_IDLE: begin
            gap_cnt_nxt = '0;
            // On a tie the port that did not own the memory last time wins.
            if (req0 && req1) begin
               if (last_owner) begin
                  state_nxt      = S_OWN0;
                  last_owner_nxt = 1'b0;
               end else begin
                  state_nxt      = S_OWN1;
                  last_owner_nxt = 1'b1;
               end
            end else if (req0) begin
               state_nxt      = S_OWN0;
               last_owner_nxt = 1'b0;
            end else if (req1) begin
               state_nxt      = S_OWN1;
               last_owner_nxt = 1'b1;
            end
         end

         S_OWN0: begin
            wb_if_s.cyc      = wb_if_p0.cyc;
            wb_if_s.stb      = wb_if_p0.stb;
            wb_if_s.we       = wb_if_p0.we;
            wb_if_s.sel      = wb_if_p0.sel;
            wb_if_s.addr     = wb_if_p0.addr;
            wb_if_s.dat_i_s  = wb_if_p0.dat_i_s;
            wb_if_p0.ack     = wb_if_s.ack;
            wb_if_p0.dat_o_s = wb_if_s.dat_o_s;
            // An ack in the same cycle as a cyc drop still completes normally.
            if (wb_if_s.ack) begin
               state_nxt   = done_to_idle ? S_IDLE : S_GAP;
               gap_cnt_nxt = '0;
            end else if (!wb_if_p0.cyc) begin
               state_nxt = S_DRAIN0;
            end
         end

         S_OWN1: begin
            wb_if_s.cyc      = wb_if_p1.cyc;
            wb_if_s.stb      = wb_if_p1.stb;
            wb_if_s.we       = wb_if_p1.we;
            wb_if_s.sel      = wb_if_p1.sel;
            wb_if_s.addr     = wb_if_p1.addr;
            wb_if_s.dat_i_s  = wb_if_p1.dat_i_s;
            wb_if_p1.ack     = wb_if_s.ack;
            wb_if_p1.dat_o_s = wb_if_s.dat_o_s;
            if (wb_if_s.ack) begin
               state_nxt   = done_to_idle ? S_IDLE : S_GAP;
               gap_cnt_nxt = '0;
            end else if (!wb_if_p1.cyc) begin
               state_nxt = S_DRAIN1;
            end
         end

         // The memory is still working on the abandoned access; its ack is
         // absorbed here and never reaches either port.
         S_DRAIN0, S_DRAIN1: begin
            if (wb_if_s.ack) begin
               state_nxt   = done_to_idle ? S_IDLE : S_GAP;
               gap_cnt_nxt = '0;
            end
         end

         S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nxt   = S_IDLE;
               gap_cnt_nxt = '0;
            end else begin
               gap_cnt_nxt = gap_cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      grant_nxt = {state_nxt == S_OWN1, state_nxt == S_OWN0};
   end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port round-robin Wishbone arbiter that shares one read-only memory secondary between two primaries, typically the instruction-fetch and data-load ports of the core. It grants exactly one primary at a time and forwards its cycle to the memory. Only the owner receives `ack` and data. It enforces a configurable recovery gap between transactions, and it drains aborted cycles so that a late memory `ack` never reaches the wrong primary.

## Interface
- `GAP_CYCLES`, default 1: idle cycles inserted after each completed or drained transaction before a new grant; 0 is legal.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `wb_if_p0` wishbone_if.secondary: requester port 0 (cyc, stb, we, sel, addr, dat_i_s in; dat_o_s, ack out).
- `wb_if_p1` wishbone_if.secondary: requester port 1, same fields.
- `wb_if_s` wishbone_if.primary: toward the memory; same field widths as the requester ports.
- `grant` output 2: one-hot current owner (bit0 = port 0), 2'b00 when no owner.

## Operation
- Request of port n: `req_n = cyc & stb` on `wb_if_pn`.
- FSM states:
  - IDLE: no owner; all forwarded strobes low.
  - OWN0 / OWN1: owner is port 0 / port 1.
  - DRAIN0 / DRAIN1: owner aborted; waiting for the memory `ack`.
  - GAP: recovery; counter runs 0..GAP_CYCLES-1.
- IDLE:
  - Exactly one req → OWNn.
  - Both req → grant the port that is not `last_owner`; update `last_owner`.
  - No req → stay.
- OWNn:
  - Memory cyc, stb, we, sel, addr, dat_i_s = owner's fields, combinational from the state register.
  - Non-owner ack = 0 and dat_o_s = 0.
  - Owner ack = memory ack; owner dat_o_s = memory dat_o_s.
  - Memory ack sampled high → GAP, or IDLE if GAP_CYCLES = 0.
  - Owner cyc sampled low with no ack that cycle → DRAINn.
- DRAINn:
  - Memory cyc/stb forced low.
  - Memory ack is swallowed; neither port sees it.
  - On ack → GAP or IDLE, as for OWNn.
  - Requests are ignored in this state.
- GAP: memory strobes low; exit to IDLE after GAP_CYCLES cycles. Requests are not sampled until IDLE.
- Memory ack in IDLE or GAP (stray, e.g. after reset) is dropped.
- The memory ignores `we`; it is forwarded unchanged regardless.
- Requesters must deassert stb in the cycle after their ack. The arbiter does not filter a stale stb; the memory's own busy guard covers it.

## Timing
- Reset: state IDLE, `last_owner` = 1 (port 0 wins the first tie), gap counter 0, `grant` = 0.
  - All memory strobes and both port acks low; both port dat_o_s = 0.
  - Reset mid-transaction aborts immediately with no drain. A following stray ack is dropped by the IDLE rule.
- Arbitration latency: request sampled at edge E → owner and forwarded strobes valid from E+1.
- Ack path: zero-cycle combinational pass-through; no added latency.
- `grant` is registered and equal to the state decode.
- Minimum spacing between the owner's ack and the next grant: 1 + GAP_CYCLES + 1 cycles.
- Ack and cyc-drop in the same cycle: counts as completion (GAP), not abort.

## Test plan
- Port 0 only, memory BUSY_CYCLES = 3, request first high in cycle 0:
  - `grant` = 01 from cycle 1.
  - Port-0 ack high only in cycle 5 with word at addr 0x4; port-1 ack never high.
  - GAP in cycle 6, IDLE in cycle 7.
- Both ports request in cycle 0 after reset:
  - Port 0 served first.
  - Port 1 granted in cycle 8 (GAP_CYCLES = 1).
  - Port 1 ack in cycle 12 with its own address's data.
- Both ports hold continuous requests for 6 transactions: grants alternate 0,1,0,1,0,1 and each port gets exactly 3 acks.
- Port 1 drops cyc in cycle 3 of its transaction:
  - State goes to DRAIN1; the memory ack in cycle 5 reaches neither port.
  - Port 0 pending since cycle 2 is granted in cycle 8, not earlier.
- Reset asserted in cycle 3 of a port-0 transaction: `grant` = 00 in cycle 4; the later memory ack is dropped; no port ack.
- GAP_CYCLES = 0 with back-to-back port-0 requests: second grant in cycle 7, second ack in cycle 11.
